// File: rtl/ysyx_24090012_wbu.sv
// Write-back unit: retires LSU results into the GPR file, sequences CSR/trap requests and
// redirects the IFU. Define WBU_PERF_CNT_EN to build the retire and CSR-stall counters.
module ysyx_24090012_wbu (
    input  logic        clk,
    input  logic        rst,

    input  logic        lsu_wbu_valid,
    output logic        lsu_wbu_ready,
    input  logic [31:0] lsu_to_wbu_inst,
    input  logic [31:0] lsu_pc,
    input  logic [31:0] lsu_dnpc,
    input  logic [31:0] lsu_result,
    input  logic [31:0] lsu_rs1_data,

    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,

    output logic        wbu_csr_valid,
    input  logic        wbu_csr_ready,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic [31:0] wbu_csr_inst,
    output logic [31:0] wbu_csr_pc,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,

    output logic        wbu_ifu_valid,
    input  logic        wbu_ifu_ready,
    output logic [31:0] wbu_next_pc,

    output logic [63:0] retire_cnt,
    output logic [31:0] csr_stall_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StCsr,
        StCommit
    } state_e;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dnpc_q, dnpc_d;
    logic [31:0] result_q, result_d;
    logic [31:0] rs1_q, rs1_d;

    // Decode of the latched instruction
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [11:0] imm12;
    logic        is_system;
    logic        is_ecall;
    logic        is_mret;
    logic        is_csrrw;
    logic        is_csrrs;
    logic        is_csr_path;
    logic        rd_writer;
    logic        rd_nonzero;

    always_comb begin
        opcode      = inst_q[6:0];
        funct3      = inst_q[14:12];
        rd          = inst_q[11:7];
        imm12       = inst_q[31:20];
        is_system   = (opcode == OpSystem);
        is_ecall    = is_system && (funct3 == 3'b000) && (imm12 == 12'h000);
        is_mret     = is_system && (funct3 == 3'b000) && (imm12 == 12'h302);
        is_csrrw    = is_system && (funct3 == 3'b001);
        is_csrrs    = is_system && (funct3 == 3'b010);
        is_csr_path = is_ecall || is_mret || is_csrrw || is_csrrs;
        rd_nonzero  = (rd != 5'd0);
        unique case (opcode)
            OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpImm, OpReg: rd_writer = 1'b1;
            default:                                             rd_writer = 1'b0;
        endcase
    end

    // Next-state and input latching
    always_comb begin
        state_d  = state_q;
        inst_d   = inst_q;
        pc_d     = pc_q;
        dnpc_d   = dnpc_q;
        result_d = result_q;
        rs1_d    = rs1_q;
        unique case (state_q)
            StIdle: begin
                if (lsu_wbu_valid) begin
                    inst_d   = lsu_to_wbu_inst;
                    pc_d     = lsu_pc;
                    dnpc_d   = lsu_dnpc;
                    result_d = lsu_result;
                    rs1_d    = lsu_rs1_data;
                    state_d  = StExec;
                end
            end
            StExec: begin
                state_d = is_csr_path ? StCsr : StCommit;
            end
            StCsr: begin
                if (wbu_csr_ready) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                if (wbu_ifu_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            inst_q   <= 32'd0;
            pc_q     <= 32'd0;
            dnpc_q   <= 32'd0;
            result_q <= 32'd0;
            rs1_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            pc_q     <= pc_d;
            dnpc_q   <= dnpc_d;
            result_q <= result_d;
            rs1_q    <= rs1_d;
        end
    end

    // Outputs decode from registered state only, so reset clears the valids immediately
    always_comb begin
        lsu_wbu_ready = (state_q == StIdle);
        wbu_csr_valid = (state_q == StCsr);
        wbu_ifu_valid = (state_q == StCommit);
        wbu_csr_inst  = inst_q;
        wbu_csr_pc    = pc_q;
        csr_addr      = imm12;
        gpr_waddr     = rd;

        gpr_wen   = 1'b0;
        gpr_wdata = 32'd0;
        if ((state_q == StExec) && !is_csr_path && rd_writer && rd_nonzero) begin
            gpr_wen   = 1'b1;
            gpr_wdata = result_q;
        end else if ((state_q == StCsr) && wbu_csr_ready && (is_csrrw || is_csrrs) &&
                     rd_nonzero) begin
            gpr_wen   = 1'b1;
            gpr_wdata = csr_rdata;
        end

        csr_wdata = 32'd0;
        if (state_q == StCsr) begin
            if (is_csrrw) begin
                csr_wdata = rs1_q;
            end else if (is_csrrs) begin
                csr_wdata = csr_rdata | rs1_q;
            end else if (is_ecall) begin
                csr_wdata = pc_q;
            end
        end

        if (is_ecall) begin
            wbu_next_pc = mtvec;
        end else if (is_mret) begin
            wbu_next_pc = mepc;
        end else begin
            wbu_next_pc = dnpc_q;
        end
    end

`ifdef WBU_PERF_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] csr_stall_cnt_q, csr_stall_cnt_d;

    always_comb begin
        retire_cnt_d    = retire_cnt_q;
        csr_stall_cnt_d = csr_stall_cnt_q;
        if ((state_q == StCommit) && wbu_ifu_ready) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
        if ((state_q == StCsr) && !wbu_csr_ready) begin
            csr_stall_cnt_d = csr_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt_q    <= 64'd0;
            csr_stall_cnt_q <= 32'd0;
        end else begin
            retire_cnt_q    <= retire_cnt_d;
            csr_stall_cnt_q <= csr_stall_cnt_d;
        end
    end

    assign retire_cnt    = retire_cnt_q;
    assign csr_stall_cnt = csr_stall_cnt_q;
`else
    assign retire_cnt    = 64'd0;
    assign csr_stall_cnt = 32'd0;
`endif

endmodule
